// File: rtl/distram_banked.sv
`default_nettype none
// ============================================================================
// Module   : distram_banked
// Purpose  : Dual-port (A read/write, B read-only) distributed RAM built from
//            128-entry banks, with a clear engine that zeroes every bank after
//            reset or on request. Optional registered read stage is enabled by
//            defining DISTRAM_BANKED_REGOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module distram_banked #(
  parameter int WIDTH  = 32,
  parameter int BANKS  = 4,
  parameter int ADDR_W = $clog2(BANKS * 128)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [WIDTH-1:0]  a_rddata,
  input  logic [WIDTH-1:0]  a_wrdata,
  input  logic [WIDTH-1:0]  a_wren,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [WIDTH-1:0]  b_rddata,
  input  logic              clr_start,
  output logic              busy
);

  localparam int SEL_W = (BANKS > 1) ? $clog2(BANKS) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  logic [6:0]          r_clr_idx;
  logic                w_busy;
  logic [SEL_W-1:0]    w_a_sel;
  logic [SEL_W-1:0]    w_b_sel;
  logic [6:0]          w_a_idx;
  logic [6:0]          w_b_idx;
  logic [WIDTH-1:0]    w_a_bank_rd [BANKS];
  logic [WIDTH-1:0]    w_b_bank_rd [BANKS];
  logic [WIDTH-1:0]    w_a_mux;
  logic [WIDTH-1:0]    w_b_mux;

  // Reset parks the engine in CLEAR so the array is zeroed on every start-up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= CLEAR;
      r_clr_idx <= 7'd0;
    end else if (clr_start) begin
      r_state   <= CLEAR;
      r_clr_idx <= 7'd0;
    end else if (r_state == CLEAR) begin
      r_clr_idx <= r_clr_idx + 7'd1;
      if (r_clr_idx == 7'd127) begin
        r_state <= IDLE;
      end
    end
  end

  assign w_busy  = (r_state == CLEAR);
  assign busy    = w_busy;
  assign w_a_idx = a_addr[6:0];
  assign w_b_idx = b_addr[6:0];

  generate
    if (BANKS > 1) begin : g_sel_multi
      assign w_a_sel = a_addr[ADDR_W-1:7];
      assign w_b_sel = b_addr[ADDR_W-1:7];
      assign w_a_mux = w_a_bank_rd[w_a_sel];
      assign w_b_mux = w_b_bank_rd[w_b_sel];
    end else begin : g_sel_single
      assign w_a_sel = '0;
      assign w_b_sel = '0;
      assign w_a_mux = w_a_bank_rd[0];
      assign w_b_mux = w_b_bank_rd[0];
    end
  endgenerate

  generate
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
      localparam logic [SEL_W-1:0] C_BANK_ID = SEL_W'(b);

      logic [WIDTH-1:0] r_mem [128];
      logic             w_wr_hit;

      assign w_wr_hit = !w_busy && (w_a_sel == C_BANK_ID);

      // Contents are intentionally not reset; only the clear engine zeroes them.
      always_ff @(posedge clk) begin
        if (w_busy) begin
          r_mem[r_clr_idx] <= '0;
        end else if (w_wr_hit) begin
          r_mem[w_a_idx] <= (r_mem[w_a_idx] & ~a_wren) | (a_wrdata & a_wren);
        end
      end

      assign w_a_bank_rd[b] = r_mem[w_a_idx];
      assign w_b_bank_rd[b] = r_mem[w_b_idx];
    end
  endgenerate

`ifdef DISTRAM_BANKED_REGOUT_EN
  logic [WIDTH-1:0] r_a_rd;
  logic [WIDTH-1:0] r_b_rd;

  // Captures pre-write contents on a same-edge write (read-before-write).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_rd <= '0;
      r_b_rd <= '0;
    end else begin
      r_a_rd <= w_busy ? '0 : w_a_mux;
      r_b_rd <= w_busy ? '0 : w_b_mux;
    end
  end

  assign a_rddata = r_a_rd;
  assign b_rddata = r_b_rd;
`else
  assign a_rddata = w_busy ? '0 : w_a_mux;
  assign b_rddata = w_busy ? '0 : w_b_mux;
`endif

endmodule
`default_nettype wire

// File: tb/tb_distram_banked.sv
`default_nettype none
// Testbench for distram_banked (BANKS=4, WIDTH=32): reference-array model
// with expected-read queues popped when the DUT output is sampled.
module tb_distram_banked;

`ifdef DISTRAM_BANKED_REGOUT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        clk;
  logic        reset_n;
  logic [8:0]  a_addr;
  logic [31:0] a_rddata;
  logic [31:0] a_wrdata;
  logic [31:0] a_wren;
  logic [8:0]  b_addr;
  logic [31:0] b_rddata;
  logic        clr_start;
  logic        busy;

  logic [31:0] model [512];
  logic [31:0] qa [$];
  logic [31:0] qb [$];
  logic [31:0] ea;
  logic [31:0] eb;
  int          n_checks;
  int          n_fail;

  distram_banked #(.WIDTH(32), .BANKS(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a_addr    (a_addr),
    .a_rddata  (a_rddata),
    .a_wrdata  (a_wrdata),
    .a_wren    (a_wren),
    .b_addr    (b_addr),
    .b_rddata  (b_rddata),
    .clr_start (clr_start),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_zero();
    for (int i = 0; i < 512; i++) model[i] = 32'h0;
  endtask

  // Drives both read addresses, queues the model's answer, waits for the output.
  task automatic drive_read(input logic [8:0] aa, input logic [8:0] ba);
    tick();
    a_addr = aa;
    b_addr = ba;
    qa.push_back(model[aa]);
    qb.push_back(model[ba]);
    if (LAT != 0) @(posedge clk);
    @(negedge clk);
    ea = qa.pop_front();
    eb = qb.pop_front();
  endtask

  task automatic write_word(input logic [8:0] ad, input logic [31:0] d, input logic [31:0] m);
    tick();
    a_addr   = ad;
    a_wrdata = d;
    a_wren   = m;
    tick();
    a_wren   = 32'h0;
    model[ad] = (model[ad] & ~m) | (d & m);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks += 3;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
    if (a_rddata !== 32'h0) begin n_fail++; $display("FAIL reset_a_rd: got %h expected 00000000", a_rddata); end
    if (b_rddata !== 32'h0) begin n_fail++; $display("FAIL reset_b_rd: got %h expected 00000000", b_rddata); end
    tick();
    reset_n = 1'b1;
    count_busy(n);
    n_checks++;
    if (n != 128) begin n_fail++; $display("FAIL reset_clear_len: got %0d cycles expected 128", n); end
    model_zero();
    drive_read(9'd0, 9'd127);
    n_checks += 2;
    if (a_rddata !== ea) begin n_fail++; $display("FAIL init_rd_0: got %h expected %h", a_rddata, ea); end
    if (b_rddata !== eb) begin n_fail++; $display("FAIL init_rd_127: got %h expected %h", b_rddata, eb); end
    drive_read(9'd128, 9'd511);
    n_checks += 2;
    if (a_rddata !== ea) begin n_fail++; $display("FAIL init_rd_128: got %h expected %h", a_rddata, ea); end
    if (b_rddata !== eb) begin n_fail++; $display("FAIL init_rd_511: got %h expected %h", b_rddata, eb); end
  endtask

  task automatic test_bank_boundary();
    write_word(9'd127, 32'hDEADBEEF, 32'hFFFF_FFFF);
    write_word(9'd128, 32'h12345678, 32'hFFFF_FFFF);
    drive_read(9'd127, 9'd128);
    n_checks += 2;
    if (a_rddata !== ea) begin n_fail++; $display("FAIL bank_rd_a127: got %h expected %h", a_rddata, ea); end
    if (b_rddata !== eb) begin n_fail++; $display("FAIL bank_rd_b128: got %h expected %h", b_rddata, eb); end
    drive_read(9'd128, 9'd127);
    n_checks += 2;
    if (a_rddata !== ea) begin n_fail++; $display("FAIL bank_rd_a128: got %h expected %h", a_rddata, ea); end
    if (b_rddata !== eb) begin n_fail++; $display("FAIL bank_rd_b127: got %h expected %h", b_rddata, eb); end
    drive_read(9'd255, 9'd383);
    n_checks += 2;
    if (a_rddata !== ea) begin n_fail++; $display("FAIL alias_rd_255: got %h expected %h", a_rddata, ea); end
    if (b_rddata !== eb) begin n_fail++; $display("FAIL alias_rd_383: got %h expected %h", b_rddata, eb); end
  endtask

  task automatic test_bit_mask();
    write_word(9'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    write_word(9'd5, 32'h0000_0000, 32'h0000_FF00);
    drive_read(9'd5, 9'd5);
    n_checks += 3;
    if (eb !== 32'hFFFF00FF) begin n_fail++; $display("FAIL mask_model: got %h expected ffff00ff", eb); end
    if (a_rddata !== ea) begin n_fail++; $display("FAIL mask_rd_a: got %h expected %h", a_rddata, ea); end
    if (b_rddata !== eb) begin n_fail++; $display("FAIL mask_rd_b: got %h expected %h", b_rddata, eb); end
  endtask

  task automatic test_same_cycle();
    write_word(9'd300, 32'h1111_2222, 32'hFFFF_FFFF);
    tick();
    a_addr   = 9'd300;
    b_addr   = 9'd300;
    a_wrdata = 32'hA5A5A5A5;
    a_wren   = 32'hFFFF_FFFF;
    qb.push_back(model[300]);
    model[300] = 32'hA5A5A5A5;
    qb.push_back(model[300]);
    if (LAT != 0) @(posedge clk);
    @(negedge clk);
    eb = qb.pop_front();
    n_checks++;
    if (b_rddata !== eb) begin n_fail++; $display("FAIL same_cycle_old: got %h expected %h", b_rddata, eb); end
    if (LAT == 0) tick(); else #1;
    a_wren = 32'h0;
    if (LAT != 0) @(posedge clk);
    @(negedge clk);
    eb = qb.pop_front();
    n_checks++;
    if (b_rddata !== eb) begin n_fail++; $display("FAIL same_cycle_new: got %h expected %h", b_rddata, eb); end
  endtask

  task automatic test_clear();
    int n;
    for (int i = 0; i < 512; i++) write_word(9'(i), 32'(i) * 32'h0101_0101 ^ 32'hC35A_0000, 32'hFFFF_FFFF);
    drive_read(9'd10, 9'd500);
    n_checks += 2;
    if (a_rddata !== ea) begin n_fail++; $display("FAIL fill_rd_10: got %h expected %h", a_rddata, ea); end
    if (b_rddata !== eb) begin n_fail++; $display("FAIL fill_rd_500: got %h expected %h", b_rddata, eb); end
    tick();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      tick();
      n++;
      if (n == 5) begin
        a_addr = 9'd10; a_wrdata = 32'h0BAD_0BAD; a_wren = 32'hFFFF_FFFF;
      end
      if (n == 6) a_wren = 32'h0;
      if (n == 20) begin
        n_checks++;
        if (a_rddata !== 32'h0 || b_rddata !== 32'h0) begin
          n_fail++; $display("FAIL busy_rd_gate: got %h/%h expected 00000000", a_rddata, b_rddata);
        end
      end
    end
    n_checks++;
    if (n != 128) begin n_fail++; $display("FAIL clr_len: got %0d cycles expected 128", n); end
    model_zero();
    for (int i = 0; i < 256; i++) begin
      drive_read(9'(i), 9'(i + 256));
      n_checks += 2;
      if (a_rddata !== ea) begin n_fail++; $display("FAIL clr_rd_a%0d: got %h expected %h", i, a_rddata, ea); end
      if (b_rddata !== eb) begin n_fail++; $display("FAIL clr_rd_b%0d: got %h expected %h", i + 256, b_rddata, eb); end
    end
    write_word(9'd42, 32'h0BADF00D, 32'hFFFF_FFFF);
    drive_read(9'd42, 9'd42);
    n_checks++;
    if (b_rddata !== eb) begin n_fail++; $display("FAIL post_clr_wr: got %h expected %h", b_rddata, eb); end
  endtask

  task automatic test_restart();
    int n;
    logic all_high;
    tick();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    all_high = 1'b1;
    for (int i = 0; i < 59; i++) begin
      tick();
      if (busy !== 1'b1) all_high = 1'b0;
    end
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    n_checks++;
    if (all_high !== 1'b1) begin n_fail++; $display("FAIL restart_busy_hold: got %b expected 1", all_high); end
    count_busy(n);
    n_checks++;
    if (n != 128) begin n_fail++; $display("FAIL restart_len: got %0d cycles expected 128", n); end
    model_zero();
  endtask

  task automatic test_reset_mid_clear();
    int n;
    write_word(9'd400, 32'h55AA55AA, 32'hFFFF_FFFF);
    drive_read(9'd400, 9'd400);
    n_checks++;
    if (a_rddata !== ea) begin n_fail++; $display("FAIL pre_rst_rd: got %h expected %h", a_rddata, ea); end
    tick();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (30) tick();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 1", busy); end
    repeat (2) tick();
    reset_n = 1'b1;
    count_busy(n);
    n_checks++;
    if (n != 128) begin n_fail++; $display("FAIL mid_rst_len: got %0d cycles expected 128", n); end
    model_zero();
    drive_read(9'd400, 9'd0);
    n_checks += 2;
    if (a_rddata !== ea) begin n_fail++; $display("FAIL mid_rst_rd_400: got %h expected %h", a_rddata, ea); end
    if (b_rddata !== eb) begin n_fail++; $display("FAIL mid_rst_rd_0: got %h expected %h", b_rddata, eb); end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    a_addr    = '0;
    b_addr    = '0;
    a_wrdata  = '0;
    a_wren    = '0;
    clr_start = 1'b0;
    model_zero();
    test_reset();
    test_bank_boundary();
    test_bit_mask();
    test_same_cycle();
    test_clear();
    test_restart();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/distram_banked.md
# distram_banked

Parametrised dual-port distributed-RAM array built from 128-deep banks. Generalises the fixed four-bank 512-entry wrapper to any power-of-two bank count. Adds a built-in clear engine that zeroes the whole array after reset or on request, plus an optional registered read stage. Used for register files, palettes and tag stores in the aq32 core, where a known-zero start state is required without a CPU clear loop.

## Interface
- `WIDTH`, 32, data width in bits.
- `BANKS`, 4, number of 128-entry banks; power of two, 1..16.
- `ADDR_W`, derived `$clog2(BANKS*128)`, address width; not to be overridden.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `a_addr`  in  ADDR_W  port A read/write address.
- `a_rddata`  out  WIDTH  port A read data.
- `a_wrdata`  in  WIDTH  port A write data.
- `a_wren`  in  WIDTH  port A per-bit write enable.
- `b_addr`  in  ADDR_W  port B read-only address.
- `b_rddata`  out  WIDTH  port B read data.
- `clr_start`  in  1  one-cycle pulse that starts a full clear.
- `busy`  out  1  clear in progress.

## Operation
- Bank select is `addr[ADDR_W-1:7]`; entry index is `addr[6:0]`. With BANKS=1 there are no select bits.
- Port A write: each bit i with `a_wren[i]`=1 takes `a_wrdata[i]` into the selected bank at the edge. Other bits and other banks are unchanged.
- Reads on both ports go through a bank-select mux, one mux per port.
- Clear FSM has two states, IDLE and CLEAR, with a 7-bit counter `clr_idx`.
  - Reset forces CLEAR with `clr_idx`=0.
  - In CLEAR, every bank writes all-zero at `clr_idx` each cycle, then `clr_idx` increments.
  - At `clr_idx`=127 the final write occurs and the FSM goes to IDLE.
  - `clr_start` in IDLE enters CLEAR with `clr_idx`=0.
  - `clr_start` while in CLEAR restarts at `clr_idx`=0.
- `busy` is 1 exactly while in CLEAR.
- While `busy`=1:
  - port A writes are dropped, with no queuing;
  - `a_rddata` and `b_rddata` are forced to 0.
- Memory contents are not reset by `reset_n` itself. Only the clear engine zeroes them.
- Reset during CLEAR restarts the clear from index 0.

## Timing
Reset values:
- `busy`=1.
- FSM=CLEAR, `clr_idx`=0.
- Registered read outputs (when configured) =0.
- Unregistered read outputs read 0 because `busy`=1.

Clear timing:
- Clear takes exactly 128 cycles from the first rising edge after `reset_n` deasserts, or from the edge sampling `clr_start`.
- `busy` falls after the 128th clear edge.
- The first accepted write is on the cycle after `busy` is seen low.

Read latency:
- Without the registered read stage, read data is combinational, 0 cycles from the address.
- A write is visible on either port from the cycle after its edge.
- Same-address A-write and B-read in one cycle: B shows old data that cycle and new data the next.

## Configuration
- `DISTRAM_BANKED_REGOUT_EN` defined:
  - `a_rddata` and `b_rddata` are registered; read latency is 1 cycle.
  - A same-edge write and read to the same address returns the old data (read-before-write).
  - The `busy` gating applies to the value captured into the register.
  - The registers reset to 0.
- Undefined: outputs are combinational, as described under Timing.

## Test plan
- Reset, BANKS=4: `busy`=1 for 128 cycles then falls. Reads of addr 0, 127, 128 and 511 all return 0x00000000.
- Write 0xDEADBEEF to addr 127 and 0x12345678 to addr 128, full mask. Then read A=127 and B=128 -> 0xDEADBEEF and 0x12345678; no cross-bank aliasing.
- Addr 5 holds 0xFFFFFFFF. Write 0x00000000 with `a_wren`=0x0000FF00 -> reads 0xFFFF00FF.
- Same cycle: A writes 0xA5A5A5A5 to addr 300 while B reads addr 300.
  - Combinational build: B shows old value, then 0xA5A5A5A5 next cycle.
  - REGOUT build: old value, then new value one cycle later.
- Fill the array, then pulse `clr_start`. `busy`=1 for 128 cycles; an A write during this window is dropped; all reads return 0 afterwards.
- Edge cases during clear:
  - `clr_start` again at cycle 60 of a clear -> `busy` stays high a further 128 cycles.
  - `reset_n` low for 2 cycles mid-clear -> clear restarts and completes 128 cycles after release.
